// File: rtl/water_level_pkg.sv
// Shared water-level types and the level-to-comparator encoding used by both
// the sensor emulator and the level priority decoder.
package water_level_pkg;

    localparam int LEVEL_W = 4;
    localparam int THERM_W = 16;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [THERM_W-1:0] therm_t;

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    // Level 15 drops the last two comparators at once; the decoder relies on this gap.
    function automatic therm_t level_to_therm(input level_t level);
        therm_t w_pattern;
        if (level == LEVEL_MAX) begin
            w_pattern = '0;
        end else begin
            w_pattern = {THERM_W{1'b1}} >> level;
        end
        return w_pattern;
    endfunction

endpackage

// File: rtl/thermometer_encoder.sv
// Combinational wrapper around level_to_therm so the encoding can be
// instantiated on its own (emulator output, decoder round-trip checks).
module thermometer_encoder
    import water_level_pkg::*;
(
    input  level_t i_level,
    output therm_t o_therm
);

    assign o_therm = level_to_therm(i_level);

endmodule

// File: rtl/level_thermo_encoder.sv
// Sensor emulator: accepts a target water level and slews the emulated level
// toward it one step per STEP_CYCLES, or jumps there directly on request.
module level_thermo_encoder
    import water_level_pkg::*;
#(
    parameter int STEP_CYCLES = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic [LEVEL_W-1:0]   target_level,
    input  logic                 target_jump,
    output logic [LEVEL_W-1:0]   cur_level,
    output logic [THERM_W-1:0]   therm_out,
    output logic                 busy,
    output logic                 done
);

    localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);

    state_t               r_state;
    level_t               r_cur_level;
    level_t               r_target;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_done;

    state_t               w_state_next;
    level_t               w_cur_level_next;
    level_t               w_target_next;
    logic [TIMER_W-1:0]   w_timer_next;
    logic                 w_done_next;
    logic                 w_accept;
    level_t               w_step_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cur_level <= '0;
            r_target    <= '0;
            r_timer     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cur_level <= w_cur_level_next;
            r_target    <= w_target_next;
            r_timer     <= w_timer_next;
            r_done      <= w_done_next;
        end
    end

    // A RAMP is only entered with target != cur_level, so the step never wraps.
    always_comb begin
        w_state_next     = r_state;
        w_cur_level_next = r_cur_level;
        w_target_next    = r_target;
        w_timer_next     = r_timer;
        w_done_next      = 1'b0;
        w_accept         = target_valid && (r_state == IDLE);
        w_step_level     = (r_cur_level < r_target) ? r_cur_level + 4'd1
                                                    : r_cur_level - 4'd1;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (target_jump || (target_level == r_cur_level)) begin
                        w_cur_level_next = target_level;
                        w_done_next      = 1'b1;
                    end else begin
                        w_target_next = target_level;
                        w_timer_next  = '0;
                        w_state_next  = RAMP;
                    end
                end
            end
            RAMP: begin
                if (r_timer == TIMER_LAST) begin
                    w_timer_next     = '0;
                    w_cur_level_next = w_step_level;
                    if (w_step_level == r_target) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    thermometer_encoder u_encoder (
        .i_level (r_cur_level),
        .o_therm (therm_out)
    );

    assign cur_level    = r_cur_level;
    assign target_ready = (r_state == IDLE);
    assign busy         = (r_state == RAMP);
    assign done         = r_done;

endmodule

// File: tb/tb_level_thermo_encoder.sv
// Directed self-checking bench for level_thermo_encoder with STEP_CYCLES = 4,
// plus a round trip of the encoder through a reference priority decoder.
module tb_level_thermo_encoder;

    logic        clk;
    logic        reset_n;
    logic        target_valid;
    logic        target_ready;
    logic [3:0]  target_level;
    logic        target_jump;
    logic [3:0]  cur_level;
    logic [15:0] therm_out;
    logic        busy;
    logic        done;

    logic [3:0]  encLevel;
    logic [15:0] encTherm;

    int checks = 0;
    int errors = 0;
    int busyCount;
    int doneCount;

    level_thermo_encoder #(.STEP_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .target_level (target_level),
        .target_jump  (target_jump),
        .cur_level    (cur_level),
        .therm_out    (therm_out),
        .busy         (busy),
        .done         (done)
    );

    thermometer_encoder encRef (
        .i_level (encLevel),
        .o_therm (encTherm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level priority decoder model: highest set comparator bit p means level 15-p.
    function automatic logic [3:0] decodeTherm(input logic [15:0] t);
        for (int i = 15; i >= 0; i--) begin
            if (t[i]) return 4'(15 - i);
        end
        return 4'd15;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] level, input logic jump);
        target_valid = 1'b1;
        target_level = level;
        target_jump  = jump;
        tick();
        target_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        target_valid = 1'b0;
        target_level = 4'd0;
        target_jump  = 1'b0;
        encLevel     = 4'd0;

        repeat (3) tick();
        checkOutput("rst_cur", 16'(cur_level), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkOutput("rst_cur_after", 16'(cur_level), 16'd0);
        checkOutput("rst_therm", therm_out, 16'hFFFF);
        checkOutput("rst_ready", 16'(target_ready), 16'd1);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);

        // Ramp up 0 -> 3
        applyStimulus(4'd3, 1'b0);
        checkOutput("up_ready_low", 16'(target_ready), 16'd0);
        busyCount = int'(busy);
        doneCount = int'(done);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 12) busyCount += int'(busy);
            doneCount += int'(done);
            if (k == 4)  checkOutput("up_lvl1", 16'(cur_level), 16'd1);
            if (k == 8)  checkOutput("up_lvl2", 16'(cur_level), 16'd2);
            if (k == 11) checkOutput("up_not_done_early", 16'(done), 16'd0);
        end
        checkOutput("up_lvl3", 16'(cur_level), 16'd3);
        checkOutput("up_done", 16'(done), 16'd1);
        checkOutput("up_busy_end", 16'(busy), 16'd0);
        checkOutput("up_ready_end", 16'(target_ready), 16'd1);
        checkOutput("up_therm", therm_out, 16'h1FFF);
        checkOutput("up_busy_cycles", 16'(busyCount), 16'd12);
        checkOutput("up_done_pulses", 16'(doneCount), 16'd1);
        tick();
        checkOutput("up_done_drop", 16'(done), 16'd0);

        // Ramp down 3 -> 1 while a second target is held on the port
        applyStimulus(4'd1, 1'b0);
        target_valid = 1'b1;
        target_level = 4'd9;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) checkOutput("dn_lvl2", 16'(cur_level), 16'd2);
        end
        target_valid = 1'b0;
        checkOutput("dn_lvl1", 16'(cur_level), 16'd1);
        checkOutput("dn_therm", therm_out, 16'h7FFF);
        checkOutput("dn_done", 16'(done), 16'd1);
        tick();
        checkOutput("dn_blocked", 16'(cur_level), 16'd1);
        checkOutput("dn_idle", 16'(busy), 16'd0);

        // Jump 1 -> 15
        applyStimulus(4'd15, 1'b1);
        checkOutput("jmp_lvl", 16'(cur_level), 16'd15);
        checkOutput("jmp_therm", therm_out, 16'h0000);
        checkOutput("jmp_done", 16'(done), 16'd1);
        checkOutput("jmp_busy", 16'(busy), 16'd0);
        tick();
        checkOutput("jmp_done_drop", 16'(done), 16'd0);

        // Same level without jump completes immediately
        applyStimulus(4'd15, 1'b0);
        checkOutput("same_done", 16'(done), 16'd1);
        checkOutput("same_busy", 16'(busy), 16'd0);
        checkOutput("same_lvl", 16'(cur_level), 16'd15);
        tick();

        // Mid-ramp reset
        applyStimulus(4'd0, 1'b1);
        checkOutput("mr_start", 16'(cur_level), 16'd0);
        tick();
        applyStimulus(4'd10, 1'b0);
        for (int k = 1; k <= 9; k++) tick();
        checkOutput("mr_lvl_before", 16'(cur_level), 16'd2);
        checkOutput("mr_busy_before", 16'(busy), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mr_async_lvl", 16'(cur_level), 16'd0);
        checkOutput("mr_async_therm", therm_out, 16'hFFFF);
        checkOutput("mr_async_busy", 16'(busy), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checkOutput("mr_ready", 16'(target_ready), 16'd1);
        checkOutput("mr_idle_busy", 16'(busy), 16'd0);
        checkOutput("mr_idle_lvl", 16'(cur_level), 16'd0);
        tick();
        checkOutput("mr_no_resume", 16'(cur_level), 16'd0);

        // Encoder hand-table points and round trip through decoder model
        encLevel = 4'd14;
        #1;
        checkOutput("enc_14", encTherm, 16'h0003);
        for (int l = 0; l < 16; l++) begin
            encLevel = 4'(l);
            #1;
            checkOutput("round_trip", 16'(decodeTherm(encTherm)), 16'(l));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_thermo_encoder.md
Name: level_thermo_encoder

Overview:
- Converts a 4-bit water level (0 = empty, 15 = 12 in) into the 16-bit comparator pattern the level priority decoder consumes.
- Slew-limits the transition: the output moves one level per STEP_CYCLES toward a new target.
- Used as the sensor emulator on the bench and on the board in place of the ADC comparators.
- A valid/ready port accepts targets; a jump flag bypasses the ramp.

Parameters:
- STEP_CYCLES, 1_000_000, clock cycles per one-level step during a ramp; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- target_valid  input  1  a new target level is offered.
- target_ready  output  1  block can accept a target; high only in IDLE.
- target_level  input  4  requested level, 0..15.
- target_jump  input  1  sampled with target; 1 means apply immediately with no ramp.
- cur_level  output  4  level currently being emulated (registered).
- therm_out  output  16  comparator pattern for cur_level.
- busy  output  1  high while in RAMP.
- done  output  1  one-cycle pulse when cur_level reaches an accepted target.

Behaviour:
- Encoding (pure function of cur_level, shared with the decoder): for L in 0..14, bits [15-L:0] are 1 and the rest are 0. L = 15 gives 16'h0000.
  - L = 0 gives 16'hFFFF, L = 1 gives 16'h7FFF, L = 14 gives 16'h0003.
  - This gap (L = 14 to 15 clears two ones) is deliberate and matches the decoder.
- Reset (async assert, sync release):
  - State IDLE, cur_level = 0, therm_out = 16'hFFFF.
  - timer = 0, busy = 0, done = 0, target_ready = 1.
- States: IDLE and RAMP.
- IDLE:
  - Handshake: a target is accepted on an edge where target_valid && target_ready.
  - If target_jump = 1 or target_level == cur_level: cur_level <= target_level on that edge, state stays IDLE, done = 1 for the following cycle.
  - Otherwise: latch the target into an internal register, timer <= 0, state <= RAMP.
- RAMP:
  - target_ready = 0 and busy = 1; target_valid is ignored (not queued).
  - Each edge: if timer == STEP_CYCLES-1, then cur_level steps by ±1 toward the latched target and timer <= 0; otherwise timer increments.
  - On the edge where cur_level becomes equal to the target, state <= IDLE and done = 1 for exactly that next cycle. target_ready is high in that same cycle.
- Latency: a ramp of |Δ| levels takes exactly |Δ| × STEP_CYCLES cycles from the accept edge to the done cycle.
- With STEP_CYCLES = 1 the block steps every cycle.
- Direction: up when target > cur_level, down when less. cur_level never wraps; arithmetic is 4-bit unsigned with a bounded step.
- Timer width: $clog2(STEP_CYCLES) with a minimum of 1; it never exceeds STEP_CYCLES-1.
- therm_out is derived combinationally from the cur_level register. It is glitch-free relative to clk and changes only on the edges where cur_level changes.
- An out-of-range target is impossible (4-bit). Level 15 is legal.
- reset_n asserted mid-ramp aborts immediately to the reset values; the latched target is discarded.
- done and busy are never high in the same cycle.

Decomposition:
- Package water_level_pkg holds:
  - LEVEL_W = 4, THERM_W = 16, LEVEL_MAX = 4'd15.
  - typedef level_t (logic [3:0]) and typedef therm_t (logic [15:0]).
  - function level_to_therm(level_t) implementing the encoding above.
  - The FSM state enum {IDLE, RAMP}.
- One combinational sub-module, thermometer_encoder (level_t in, therm_t out), wraps level_to_therm. The top instantiates it on cur_level.
- The decoder bench reuses the sub-module for round-trip checks.

Test Plan (STEP_CYCLES = 4):
- Reset: hold reset_n = 0, then release → cur_level = 0, therm_out = 16'hFFFF, target_ready = 1, busy = 0, done = 0.
- Ramp up: accept target 3, jump 0 → busy for 12 cycles; cur_level reads 1, 2, 3 at accept+4, +8, +12. done pulses once at +12. therm_out ends at 16'h1FFF.
- Ramp down plus blocked valid: from 3, accept target 1; hold target_valid with target 9 during the ramp → not accepted. cur_level = 1 after 8 cycles, therm_out = 16'h7FFF.
- Jump and same-level:
  - From 1, accept target 15 with jump 1 → next cycle cur_level = 15, therm_out = 16'h0000, done = 1, busy never high.
  - Then accept 15 again with jump 0 → immediate done, no RAMP.
- Mid-ramp reset: from 0, accept target 10; assert reset_n at cycle 9 → cur_level = 0 and therm_out = 16'hFFFF asynchronously. After release the FSM is in IDLE with ready = 1.
- Round trip: sweep all 16 levels through thermometer_encoder into the level priority decoder → decoder output equals level for 0..15.
